// File: rtl/core_pkg.sv
// Shared core definitions: opcode constants and hazard FSM states.
package core_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;

  typedef enum logic {HZ_IDLE, HZ_WAIT} hz_state_t;

endpackage

// File: rtl/reg_use_decode.sv
// Decodes which source registers an opcode actually reads.
// Purely combinational, zero latency; no flow control.
module reg_use_decode
  import core_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       uses_rs1,
  output logic       uses_rs2
);

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_LOAD, OP_IALU: uses_rs1 = 1'b1;
      OP_STORE, OP_RTYPE, OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall, branch flush and data-memory hold control for the 5-stage core.
// Strobes are zero-latency combinational; a slow dmem access freezes the whole pipe via pipe_hold.
module hazard_unit
  import core_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 64,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       ifid_opcode,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rd,
  input  logic             exmem_branch_taken,
  input  logic             exmem_mem_access,
  input  logic             dmem_ready,
  output logic             stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [15:0] MAX_WAIT_C = 16'(MAX_WAIT);

  hz_state_t        state, state_nxt;
  logic [15:0]      wait_cnt, wait_cnt_nxt;
  logic             hold_raw;
  logic             timeout_q;
  logic [CNT_W-1:0] cnt_q;
  logic             uses_rs1, uses_rs2;
  logic             load_use;

  reg_use_decode u_decode (
    .opcode   (ifid_opcode),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  // rd of x0 also covers x0 sources, since a match would need rs == 0
  assign load_use = idex_memread && (idex_rd != 5'd0) &&
                    ((uses_rs1 && (ifid_rs1 == idex_rd)) ||
                     (uses_rs2 && (ifid_rs2 == idex_rd)));

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    hold_raw     = 1'b0;
    case (state)
      HZ_IDLE: begin
        if (exmem_mem_access && !dmem_ready) begin
          hold_raw     = 1'b1;
          state_nxt    = HZ_WAIT;
          wait_cnt_nxt = 16'd1;
        end
      end
      HZ_WAIT: begin
        if (dmem_ready) begin
          state_nxt = HZ_IDLE;
        end else begin
          hold_raw = 1'b1;
          if (wait_cnt != MAX_WAIT_C) wait_cnt_nxt = wait_cnt + 16'd1;
        end
      end
      default: state_nxt = HZ_IDLE;
    endcase
  end

  always_comb begin
    stall      = 1'b0;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pipe_hold  = 1'b0;
    if (!rst) begin
      if (hold_raw) begin
        pipe_hold  = 1'b1;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
      end else if (exmem_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        stall      = 1'b1;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HZ_IDLE;
      wait_cnt  <= 16'd0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state_nxt == HZ_WAIT && wait_cnt_nxt == MAX_WAIT_C) timeout_q <= 1'b1;
      if ((stall || pipe_hold) && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign mem_timeout  = timeout_q & ~rst;
  assign stall_cycles = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: driver pushes model expectations, negedge monitor compares.
module tb_hazard_unit;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [6:0]       ifid_opcode;
  logic [4:0]       ifid_rs1, ifid_rs2, idex_rd;
  logic             idex_memread, exmem_branch_taken, exmem_mem_access, dmem_ready;
  logic             stall, pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  always #5 clk = ~clk;

  hazard_unit #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .ifid_opcode        (ifid_opcode),
    .ifid_rs1           (ifid_rs1),
    .ifid_rs2           (ifid_rs2),
    .idex_memread       (idex_memread),
    .idex_rd            (idex_rd),
    .exmem_branch_taken (exmem_branch_taken),
    .exmem_mem_access   (exmem_mem_access),
    .dmem_ready         (dmem_ready),
    .stall              (stall),
    .pc_write           (pc_write),
    .ifid_write         (ifid_write),
    .ifid_flush         (ifid_flush),
    .idex_flush         (idex_flush),
    .pipe_hold          (pipe_hold),
    .mem_timeout        (mem_timeout),
    .stall_cycles       (stall_cycles)
  );

  typedef struct packed {
    bit       rst;
    bit [6:0] op;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit       memread;
    bit [4:0] rd;
    bit       br;
    bit       acc;
    bit       ready;
  } in_t;

  typedef struct packed {
    logic             stall;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             pipe_hold;
    logic             mem_timeout;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  // Reference model state: memory wait in progress, cycles waited, sticky timeout, stall count
  bit m_wait;
  int m_wcnt;
  bit m_to;
  int m_sc;

  function automatic bit reads_rs1(bit [6:0] op);
    return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
           op == 7'b1100011 || op == 7'b0010011;
  endfunction

  function automatic bit reads_rs2(bit [6:0] op);
    return op == 7'b0100011 || op == 7'b0110011 || op == 7'b1100011;
  endfunction

  task automatic drive(input in_t v, input string tag);
    exp_t e;
    bit   hold, lu;
    @(posedge clk);
    #1;
    rst = v.rst; ifid_opcode = v.op; ifid_rs1 = v.rs1; ifid_rs2 = v.rs2;
    idex_memread = v.memread; idex_rd = v.rd; exmem_branch_taken = v.br;
    exmem_mem_access = v.acc; dmem_ready = v.ready;

    e = '0;
    e.pc_write = 1'b1;
    e.ifid_write = 1'b1;
    if (v.rst) begin
      m_wait = 0; m_wcnt = 0; m_to = 0; m_sc = 0;
    end else begin
      hold = m_wait ? !v.ready : (v.acc && !v.ready);
      lu = v.memread && v.rd != 0 &&
           ((reads_rs1(v.op) && v.rs1 == v.rd) || (reads_rs2(v.op) && v.rs2 == v.rd));
      e.pipe_hold = hold;
      e.mem_timeout = m_to;
      e.cnt = CNT_W'(m_sc);
      if (hold) begin
        e.pc_write = 0; e.ifid_write = 0;
      end else if (v.br) begin
        e.ifid_flush = 1; e.idex_flush = 1;
      end else if (lu) begin
        e.stall = 1; e.pc_write = 0; e.ifid_write = 0;
      end
      if (m_wait) begin
        if (v.ready) m_wait = 0;
        else m_wcnt++;
      end else if (v.acc && !v.ready) begin
        m_wait = 1; m_wcnt = 1;
      end
      if (m_wait && m_wcnt >= MAX_WAIT) m_to = 1;
      if ((e.stall || hold) && m_sc < (1 << CNT_W) - 1) m_sc++;
    end
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  always @(negedge clk) begin
    exp_t  e, a;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {stall, pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, mem_timeout, stall_cycles};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s (vec %0d): actual stall/pcw/ifw/iff/idf/hold/to/cnt=%b required=%b",
                 t, vectors, a, e);
      end
    end
  end

  function automatic in_t idle_in();
    in_t v = '0;
    v.ready = 1'b1;
    return v;
  endfunction

  task automatic do_reset(input int n);
    in_t v = idle_in();
    v.rst = 1;
    for (int i = 0; i < n; i++) drive(v, "reset");
  endtask

  initial begin
    in_t v;
    bit [6:0] ops[6];
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
    ops[3] = 7'b1100011; ops[4] = 7'b0010011; ops[5] = 7'b1101111;
    rst = 1; ifid_opcode = 0; ifid_rs1 = 0; ifid_rs2 = 0; idex_memread = 0;
    idex_rd = 0; exmem_branch_taken = 0; exmem_mem_access = 0; dmem_ready = 1;

    do_reset(2);
    drive(idle_in(), "idle");

    // add x6,x5,x7 behind lw x5, then rd moved to x8
    v = idle_in(); v.op = 7'b0110011; v.rs1 = 5; v.rs2 = 7; v.memread = 1; v.rd = 5;
    drive(v, "loaduse_rs1");
    v.rd = 8;
    drive(v, "loaduse_other_rd");
    v.rs1 = 1; v.rd = 7;
    drive(v, "loaduse_rs2");

    v = idle_in(); v.op = 7'b0110011; v.rs1 = 0; v.memread = 1; v.rd = 0;
    drive(v, "rd_x0");
    v = idle_in(); v.op = 7'b0010011; v.rs1 = 1; v.rs2 = 5; v.memread = 1; v.rd = 5;
    drive(v, "ialu_rs2_unused");
    v = idle_in(); v.op = 7'b0100011; v.rs1 = 2; v.rs2 = 9; v.memread = 1; v.rd = 9;
    drive(v, "store_rs2");

    v = idle_in(); v.op = 7'b0110011; v.rs1 = 5; v.memread = 1; v.rd = 5; v.br = 1;
    drive(v, "branch_over_loaduse");

    v = idle_in(); v.acc = 1; v.ready = 0;
    for (int i = 0; i < 3; i++) drive(v, "hold_wait");
    v.ready = 1;
    drive(v, "hold_release");
    drive(idle_in(), "after_release");
    v = idle_in(); v.acc = 1;
    drive(v, "access_ready_same_cycle");

    do_reset(1);
    v = idle_in(); v.acc = 1; v.ready = 0;
    for (int i = 0; i < 8; i++) drive(v, "timeout_wait");
    do_reset(1);
    v = idle_in(); v.ready = 0;
    drive(v, "idle_after_timeout_rst");
    drive(v, "idle_after_timeout_rst");

    v = idle_in(); v.acc = 1; v.ready = 0;
    for (int i = 0; i < 20; i++) drive(v, "saturate");
    drive(idle_in(), "saturate_release");
    drive(idle_in(), "saturate_idle");

    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      v.rst     = ($urandom_range(0, 59) == 0);
      v.op      = ops[$urandom_range(0, 5)];
      v.rs1     = 5'($urandom_range(0, 7));
      v.rs2     = 5'($urandom_range(0, 7));
      v.memread = ($urandom_range(0, 1) == 1);
      v.rd      = 5'($urandom_range(0, 7));
      v.br      = ($urandom_range(0, 4) == 0);
      v.acc     = ($urandom_range(0, 9) < 3);
      v.ready   = ($urandom_range(0, 1) == 1);
      drive(v, "random");
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: actual %0d pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1);
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard and stall controller for the 5-stage core. It produces the `stall` consumed by `control_unit`, which zeroes the ID-stage control bundle to inject a bubble. It also generates the PC/IF-ID write enables, the flush strobes and a whole-pipeline hold for multi-cycle data-memory accesses. It sits beside the decode stage and observes the ID/EX and EX/MEM pipeline registers and the data-memory handshake.

## Interface
Parameters:
- `MAX_WAIT`, 64: data-memory wait cycles before `mem_timeout` sets; range 2..65535.
- `CNT_W`, 16: width of the stall performance counter.

Ports:
- `clk` input 1: core clock.
- `rst` input 1: synchronous, active-high reset. One clock domain; reset is sampled on the `clk` rising edge.
- `ifid_opcode` input 7: opcode of the instruction in IF/ID.
- `ifid_rs1` input 5: rs1 field of the instruction in IF/ID.
- `ifid_rs2` input 5: rs2 field of the instruction in IF/ID.
- `idex_memread` input 1: the instruction in ID/EX is a load.
- `idex_rd` input 5: destination register of the instruction in ID/EX.
- `exmem_branch_taken` input 1: the branch in EX/MEM resolved taken.
- `exmem_mem_access` input 1: the EX/MEM instruction has memread or memwrite set.
- `dmem_ready` input 1: data memory completes the current access this cycle.
- `stall` output 1: to `control_unit`; bubble into ID/EX.
- `pc_write` output 1: PC register write enable.
- `ifid_write` output 1: IF/ID register write enable.
- `ifid_flush` output 1: clear IF/ID to NOP.
- `idex_flush` output 1: clear ID/EX control bits.
- `pipe_hold` output 1: freeze all pipeline registers and the PC.
- `mem_timeout` output 1: sticky error flag.
- `stall_cycles` output CNT_W: saturating count of stall-or-hold cycles.

## Operation
Register-use decode of `ifid_opcode`:
- rs1 used for LOAD 0000011, STORE 0100011, R 0110011, BRANCH 1100011 and I-ALU 0010011.
- rs2 used for STORE, R and BRANCH only.
- A source of x0 never creates a hazard.

Load-use condition: `idex_memread` is high, `idex_rd` is not 0, and `idex_rd` matches a used rs1 or rs2.

FSM for the memory hold, with states IDLE and WAIT:
- IDLE, `exmem_mem_access` high and `dmem_ready` low: `pipe_hold`=1, go to WAIT, wait counter loads 1.
- IDLE, access with `dmem_ready` high in the same cycle: no hold, stay in IDLE.
- WAIT, `dmem_ready` low: `pipe_hold`=1 and the wait counter increments.
- WAIT, `dmem_ready` high: `pipe_hold`=0 in that cycle, go to IDLE.
- Wait counter reaching MAX_WAIT: `mem_timeout` sets. The FSM stays in WAIT; `mem_timeout` clears only on `rst`.

Priority, highest first:
1. Hold (`pipe_hold`=1): `pc_write`=`ifid_write`=0; `stall`, `ifid_flush` and `idex_flush` are 0. A branch or load-use condition is evaluated again after release.
2. Branch taken: `ifid_flush`=`idex_flush`=1 and `stall`=0, even if load-use also holds, because the dependent instruction is discarded.
3. Load-use: `stall`=1 and `pc_write`=`ifid_write`=0 for exactly one cycle. The next cycle the load has advanced and the condition clears.
4. Otherwise `pc_write`=`ifid_write`=1 and all other strobes are 0.

`stall_cycles` increments each cycle in which `stall` or `pipe_hold` is 1. It saturates at all-ones and does not wrap.

## Timing
- `stall`, `pc_write`, `ifid_write`, both flushes and the IDLE-state `pipe_hold` are combinational from the inputs and the current state. Zero-cycle latency lets `control_unit` bubble in the same cycle.
- FSM state, wait counter, `mem_timeout` and `stall_cycles` are registered and update on the `clk` rising edge.
- While `rst`=1 the outputs are: `stall`=0, `pc_write`=1, `ifid_write`=1, `ifid_flush`=0, `idex_flush`=0, `pipe_hold`=0, `mem_timeout`=0, `stall_cycles`=0. The FSM returns to IDLE on the next edge.
- Reset asserted mid-WAIT abandons the access. No hold is carried over.

## Structure
- Shared package `core_pkg`:
  - opcode constants `OP_LOAD`, `OP_STORE`, `OP_RTYPE`, `OP_BRANCH`, `OP_IALU`;
  - `typedef enum logic {HZ_IDLE, HZ_WAIT} hz_state_t`.
- One sub-module, `reg_use_decode`: opcode in, `uses_rs1`/`uses_rs2` out, purely combinational. It is reused by the forwarding unit.

## Test plan
- Load `lw x5` in ID/EX (`idex_memread`=1, `idex_rd`=5) with `add x6,x5,x7` in IF/ID → `stall`=1, `pc_write`=0 for 1 cycle; with `idex_rd` changed to 8 → `stall`=0.
- `idex_rd`=0 with the IF/ID instruction using rs1=0 → no stall. I-ALU instruction with rs2 field=5 and `idex_rd`=5 → no stall.
- Load-use true together with `exmem_branch_taken`=1 → `ifid_flush`=`idex_flush`=1, `stall`=0, `pc_write`=1.
- `exmem_mem_access`=1 with `dmem_ready` low for 3 cycles then high → `pipe_hold`=1 for 3 cycles and 0 on the ready cycle; `stall_cycles` increases by 3.
- MAX_WAIT=4 and `dmem_ready` never asserted → `mem_timeout`=1 after the 4th wait cycle and it stays set; `rst` clears it and the FSM returns to IDLE.
- CNT_W=4 with continuous hold for 20 cycles → `stall_cycles` saturates at 15.
